alu_seq_n: RTL
==============

ALU_SEQ_N -- requirements
Module: alu_seq_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port ALUControl  input  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 0011 MUL.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port Result  output  WIDTH  registered result; low half for MUL.
REQ-009 SHALL have port ResultHi  output  WIDTH  high half of MUL product; 0 for all other ops.
REQ-010 SHALL have port Zero  output  1  Result == 0.
REQ-011 SHALL have port Carry_out  output  1  carry out of MSB for ADD/SUB/SLT; 0 otherwise.
REQ-012 SHALL have port Overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
REQ-013 SHALL have port Busy  output  1  high from cycle after accepted Start until Done cycle.
REQ-014 SHALL have port Done  output  1  one-cycle pulse, outputs valid that cycle.

Function
REQ-015 SHALL use FSM states IDLE, EXEC, MULT, DONE.
REQ-016 IDLE with Start=1 SHALL capture A, B, ALUControl into internal registers and go to EXEC (MUL code: MULT).
REQ-017 EXEC SHALL compute the op on captured operands, register outputs, go to DONE; Done asserted 2 cycles after Start sample edge.
REQ-018 SUB SHALL be A + ~B + 1; Carry_out = carry of that sum (1 means no borrow).
REQ-019 SLT SHALL produce Result = {WIDTH-1 zeros, sum_msb XOR overflow} of A-B, signed compare.
REQ-020 Overflow SHALL be (A_msb == B'_msb) && (sum_msb != A_msb), B' being B or ~B.
REQ-021 MULT SHALL perform unsigned shift-add, one partial product per cycle, exactly WIDTH cycles, then DONE; Done asserted WIDTH+2 cycles after Start edge.
REQ-022 MUL SHALL give {ResultHi,Result} = A*B (2*WIDTH bits, unsigned); Zero from Result only; Carry_out, Overflow = 0.
REQ-023 Undefined ALUControl codes SHALL complete via EXEC with Result=0, Zero=1, other flags 0.
REQ-024 DONE SHALL assert Done for one cycle and return to IDLE; Start in DONE SHALL be ignored.
REQ-025 Start while Busy SHALL be ignored; input changes while Busy SHALL not affect the operation.
REQ-026 Result/ResultHi/flags SHALL hold their last values until the next operation's Done cycle.
REQ-027 Start held high continuously SHALL yield back-to-back operations, one accepted per IDLE visit.

Reset
REQ-028 Reset SHALL force IDLE, Result=0, ResultHi=0, Zero=1, Carry_out=0, Overflow=0, Busy=0, Done=0.
REQ-029 Reset mid-operation (EXEC/MULT/DONE) SHALL abort without Done; Reset has priority over Start.

Configuration
REQ-030 Macro ALU_SEQ_MUL_EN defined SHALL include the MULT state, multiplier datapath and code 0011 as in REQ-021/022.
REQ-031 Without ALU_SEQ_MUL_EN, code 0011 SHALL behave as undefined (REQ-023), ResultHi SHALL be tied 0, no MULT logic.

Verification (WIDTH=8)
REQ-032 ADD A=0x7F B=0x01 -> Done at cycle 2: Result=0x80, Overflow=1, Carry_out=0, Zero=0.
REQ-033 SUB A=0x05 B=0x05 -> Result=0x00, Zero=1, Carry_out=1, Overflow=0; SLT A=0xFF B=0x01 -> Result=0x01.
REQ-034 MUL (macro on) A=0xFF B=0xFF -> Done at cycle 10: ResultHi=0xFE, Result=0x01; macro off -> Result=0, Done at cycle 2.
REQ-035 Second Start pulses and operand changes during MUL -> ignored, single Done, product unchanged.
REQ-036 Reset asserted in cycle 4 of MUL -> no Done, Busy=0, Result=0, Zero=1 next cycle; new Start then completes normally.

Source files
------------

// File: rtl/alu_seq_n.sv
// Sequential ALU: captures operands on Start, computes in EXEC (or MULT),
// pulses Done with registered Result/ResultHi/Zero/Carry_out/Overflow.
// Ports: Clock, Reset (sync, high), Start, ALUControl[3:0], A, B -> Result,
// ResultHi, Zero, Carry_out, Overflow, Busy, Done.
// Optional macro ALU_SEQ_MUL_EN adds the shift-add multiplier (op 0011).
module alu_seq_n #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Carry_out,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MULT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, cout_q, ovf_q;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf_raw;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] p_hi, p_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p_add;

  // Partial product for the multiplier bit currently at p_lo[0].
  assign p_add = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
  assign ResultHi = hi_q;
`else
  assign ResultHi = '0;
`endif

  // SUB and SLT share the A + ~B + 1 adder path.
  assign sub     = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign b_eff   = sub ? ~b_q : b_q;
  assign sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign ovf_raw = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_ADD, OP_SUB: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = ovf_raw;
      end
      OP_SLT: begin
        alu_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
        alu_cout = sum[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef ALU_SEQ_MUL_EN
          state_nxt = (ALUControl == OP_MUL) ? MULT : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
      EXEC: state_nxt = DONE;
`ifdef ALU_SEQ_MUL_EN
      MULT: if (cnt == CNT_LAST) state_nxt = DONE;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b1;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_q   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= ALUControl;
`ifdef ALU_SEQ_MUL_EN
            p_hi <= '0;
            p_lo <= B;
            cnt  <= '0;
`endif
          end
        end
        EXEC: begin
          res_q  <= alu_res;
          zero_q <= (alu_res == '0);
          cout_q <= alu_cout;
          ovf_q  <= alu_ovf;
`ifdef ALU_SEQ_MUL_EN
          hi_q   <= '0;
`endif
        end
`ifdef ALU_SEQ_MUL_EN
        // WIDTH shift-add steps, then one cycle to publish the product.
        MULT: begin
          if (cnt == CNT_LAST) begin
            res_q  <= p_lo;
            hi_q   <= p_hi;
            zero_q <= (p_lo == '0);
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end else begin
            p_hi <= p_add[WIDTH:1];
            p_lo <= {p_add[0], p_lo[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign Result    = res_q;
  assign Zero      = zero_q;
  assign Carry_out = cout_q;
  assign Overflow  = ovf_q;
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);

endmodule
